// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control/datapath bundle between the SISC controller and the
// instruction fetch unit. The controller owns the master modport and the fetch
// unit owns the slave modport.
// Optional feature macro: FETCH_ICOUNT_EN adds the icount fetch counter signal.
interface fetch_unit_if #(
    parameter int PC_W = 16
);
    // Strobes and data from the controller and the instruction memory
    logic            ir_load;
    logic            pc_write;
    logic            pc_sel;
    logic            br_sel;
    logic            pc_rst;
    logic            stat_en;
    logic [3:0]      alu_stat;
    logic [31:0]     imem_data;

    // Results returned by the fetch unit
    logic [PC_W-1:0] imem_addr;
    logic [3:0]      opcode;
    logic [3:0]      mm;
    logic [15:0]     imm;
    logic [3:0]      stat;
    logic [PC_W-1:0] br_addr;
    logic            halted;
`ifdef FETCH_ICOUNT_EN
    logic [15:0]     icount;
`endif

    modport master (
        output ir_load, pc_write, pc_sel, br_sel, pc_rst, stat_en, alu_stat, imem_data,
        input  imem_addr, opcode, mm, imm, stat, br_addr, halted
`ifdef FETCH_ICOUNT_EN
        , input icount
`endif
    );

    modport slave (
        input  ir_load, pc_write, pc_sel, br_sel, pc_rst, stat_en, alu_stat, imem_data,
        output imem_addr, opcode, mm, imm, stat, br_addr, halted
`ifdef FETCH_ICOUNT_EN
        , output icount
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: SISC instruction-side datapath. Holds PC, IR and the status
// register, computes branch targets and latches a sticky halt on an HLT load.
// Optional feature macro: FETCH_ICOUNT_EN adds a saturating 16-bit fetch
// counter driven onto bus.icount.
module fetch_unit #(
    parameter int PC_W = 16
) (
    input  logic          clk,
    input  logic          rst_f,
    fetch_unit_if.slave   bus
);
    // Instruction width is architectural and fixed.
    localparam int IR_W = 32;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [PC_W-1:0] r_pc;
    logic [IR_W-1:0] r_ir;
    logic [3:0]      r_stat;
    logic            r_halted;

    logic [PC_W-1:0] w_imm;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_br_addr;
    logic [PC_W-1:0] w_pc_next;
    logic            w_ir_accept;

    // The immediate is the low 16 IR bits, resized to the PC width.
    assign w_imm       = PC_W'(r_ir[15:0]);
    assign w_pc_inc    = r_pc + PC_W'(1);
    // Relative targets use the PC as it stands after the fetch increment.
    assign w_br_addr   = bus.br_sel ? w_imm : (r_pc + w_imm);
    assign w_pc_next   = bus.pc_sel ? w_br_addr : w_pc_inc;
    // Once halted, no further instruction is accepted.
    assign w_ir_accept = bus.ir_load && !r_halted;

    assign bus.imem_addr = r_pc;
    assign bus.opcode    = r_ir[31:28];
    assign bus.mm        = r_ir[27:24];
    assign bus.imm       = r_ir[15:0];
    assign bus.stat      = r_stat;
    assign bus.br_addr   = w_br_addr;
    assign bus.halted    = r_halted;

    // PC update: clear beats write; halt freezes writes but not the clear.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_pc <= '0;
        end else if (bus.pc_rst) begin
            r_pc <= '0;
        end else if (bus.pc_write && !r_halted) begin
            r_pc <= w_pc_next;
        end
    end

    // IR capture and halt detection on the instruction being loaded.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_ir     <= '0;
            r_halted <= 1'b0;
        end else if (w_ir_accept) begin
            r_ir <= bus.imem_data;
            if (bus.imem_data[31:28] == OP_HLT) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Status flags are written back regardless of halt state.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_stat <= '0;
        end else if (bus.stat_en) begin
            r_stat <= bus.alu_stat;
        end
    end

`ifdef FETCH_ICOUNT_EN
    logic [15:0] r_icount;

    // Count accepted fetches, sticking at all-ones; only rst_f clears it.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_icount <= '0;
        end else if (w_ir_accept && (r_icount != 16'hFFFF)) begin
            r_icount <= r_icount + 16'd1;
        end
    end

    assign bus.icount = r_icount;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven check of fetch_unit plus hand-written async reset
// sequence. Works with or without FETCH_ICOUNT_EN defined.
`timescale 1ns/1ps
module tb_fetch_unit;
    logic clk;
    logic rst_f;

    fetch_unit_if #(.PC_W(16)) bus ();

    fetch_unit #(.PC_W(16)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        il, pw, ps, bs, pr, se;
        logic [3:0]  alu;
        logic [31:0] data;
        logic [15:0] e_pc;
        logic [31:0] e_ir;
        logic [3:0]  e_stat;
        logic        e_halt;
        logic [15:0] e_br;
        logic [15:0] e_icnt;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    int n_checks;
    int n_fail;

    function automatic vec_t mk(logic il, logic pw, logic ps, logic bs, logic pr, logic se,
                                logic [3:0] alu, logic [31:0] data, logic [15:0] e_pc,
                                logic [31:0] e_ir, logic [3:0] e_stat, logic e_halt,
                                logic [15:0] e_br, logic [15:0] e_icnt);
        vec_t v;
        v.il = il; v.pw = pw; v.ps = ps; v.bs = bs; v.pr = pr; v.se = se;
        v.alu = alu; v.data = data; v.e_pc = e_pc; v.e_ir = e_ir;
        v.e_stat = e_stat; v.e_halt = e_halt; v.e_br = e_br; v.e_icnt = e_icnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.ir_load   = v.il;
        bus.pc_write  = v.pw;
        bus.pc_sel    = v.ps;
        bus.br_sel    = v.bs;
        bus.pc_rst    = v.pr;
        bus.stat_en   = v.se;
        bus.alu_stat  = v.alu;
        bus.imem_data = v.data;
    endtask

    task automatic idle();
        bus.ir_load = 1'b0; bus.pc_write = 1'b0; bus.pc_sel = 1'b0; bus.br_sel = 1'b0;
        bus.pc_rst = 1'b0; bus.stat_en = 1'b0; bus.alu_stat = 4'h0; bus.imem_data = 32'h0;
    endtask

    task automatic chk_icount(input int idx, input logic [15:0] exp);
`ifdef FETCH_ICOUNT_EN
        chk("icount", idx, {16'h0, bus.icount}, {16'h0, exp});
`else
        if (idx < 0) $display("step %0d expected icount %h (feature off)", idx, exp);
`endif
    endtask

    task automatic chk_state(input int idx, input vec_t v);
        chk("pc",      idx, {16'h0, bus.imem_addr}, {16'h0, v.e_pc});
        chk("opcode",  idx, {28'h0, bus.opcode},    {28'h0, v.e_ir[31:28]});
        chk("mm",      idx, {28'h0, bus.mm},        {28'h0, v.e_ir[27:24]});
        chk("imm",     idx, {16'h0, bus.imm},       {16'h0, v.e_ir[15:0]});
        chk("stat",    idx, {28'h0, bus.stat},      {28'h0, v.e_stat});
        chk("halted",  idx, {31'h0, bus.halted},    {31'h0, v.e_halt});
        chk("br_addr", idx, {16'h0, bus.br_addr},   {16'h0, v.e_br});
        chk_icount(idx, v.e_icnt);
    endtask

    initial begin
        vec_t z;
        n_checks = 0;
        n_fail   = 0;

        //            il pw ps bs pr se alu   data          pc       ir            st    h  br       icnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 32'h10000005, 16'h0000, 32'h10000005, 4'h0, 0, 16'h0005, 16'd1);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0, 4'h0, 32'h0,        16'h0001, 32'h10000005, 4'h0, 0, 16'h0006, 16'd1);
        vecs[2]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 32'h10000005, 16'h0001, 32'h10000005, 4'h0, 0, 16'h0006, 16'd2);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 4'h0, 32'h0,        16'h0002, 32'h10000005, 4'h0, 0, 16'h0007, 16'd2);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 32'h10000005, 16'h0002, 32'h10000005, 4'h0, 0, 16'h0007, 16'd3);
        vecs[5]  = mk(0, 1, 0, 0, 0, 0, 4'h0, 32'h0,        16'h0003, 32'h10000005, 4'h0, 0, 16'h0008, 16'd3);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 32'h20000010, 16'h0003, 32'h20000010, 4'h0, 0, 16'h0013, 16'd4);
        vecs[7]  = mk(0, 1, 0, 0, 0, 0, 4'h0, 32'h0,        16'h0004, 32'h20000010, 4'h0, 0, 16'h0014, 16'd4);
        // relative branch from PC 4 by 0x10, then absolute branch to 0x10
        vecs[8]  = mk(0, 1, 1, 0, 0, 0, 4'h0, 32'h0,        16'h0014, 32'h20000010, 4'h0, 0, 16'h0024, 16'd4);
        vecs[9]  = mk(0, 1, 1, 1, 0, 0, 4'h0, 32'h0,        16'h0010, 32'h20000010, 4'h0, 0, 16'h0010, 16'd4);
        vecs[10] = mk(0, 0, 0, 0, 0, 1, 4'hA, 32'h0,        16'h0010, 32'h20000010, 4'hA, 0, 16'h0020, 16'd4);
        // pc_rst beats pc_write; simultaneous ir_load still loads
        vecs[11] = mk(1, 1, 1, 0, 1, 0, 4'h0, 32'h3A001234, 16'h0000, 32'h3A001234, 4'hA, 0, 16'h1234, 16'd5);
        vecs[12] = mk(1, 0, 0, 1, 0, 0, 4'h0, 32'h4000FFFF, 16'h0000, 32'h4000FFFF, 4'hA, 0, 16'hFFFF, 16'd6);
        vecs[13] = mk(0, 1, 1, 1, 0, 0, 4'h0, 32'h0,        16'hFFFF, 32'h4000FFFF, 4'hA, 0, 16'hFFFF, 16'd6);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 4'h0, 32'h0,        16'hFFFF, 32'h4000FFFF, 4'hA, 0, 16'hFFFE, 16'd6);
        vecs[15] = mk(0, 1, 0, 0, 0, 0, 4'h0, 32'h0,        16'h0000, 32'h4000FFFF, 4'hA, 0, 16'hFFFF, 16'd6);
        // HLT load with pc_write: PC advances once, then everything freezes
        vecs[16] = mk(1, 1, 0, 0, 0, 0, 4'h0, 32'hF0000000, 16'h0001, 32'hF0000000, 4'hA, 1, 16'h0001, 16'd7);
        vecs[17] = mk(1, 1, 0, 0, 0, 0, 4'h0, 32'h80000000, 16'h0001, 32'hF0000000, 4'hA, 1, 16'h0001, 16'd7);
        vecs[18] = mk(0, 0, 0, 0, 0, 1, 4'h1, 32'h0,        16'h0001, 32'hF0000000, 4'h1, 1, 16'h0001, 16'd7);
        vecs[19] = mk(0, 0, 0, 0, 1, 0, 4'h0, 32'h0,        16'h0000, 32'hF0000000, 4'h1, 1, 16'h0000, 16'd7);
        vecs[20] = mk(1, 1, 0, 0, 0, 0, 4'h0, 32'h80000000, 16'h0000, 32'hF0000000, 4'h1, 1, 16'h0000, 16'd7);

        z = mk(0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 16'h0, 32'h0, 4'h0, 0, 16'h0, 16'd0);

        // Power-on reset, checked while still held
        idle();
        rst_f = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_state(-1, z);
        $display("reset: pc=%h opcode=%h stat=%h halted=%b", bus.imem_addr, bus.opcode, bus.stat, bus.halted);
        @(negedge clk);
        rst_f = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk_state(i, vecs[i]);
            $display("step %0d: il=%b pw=%b ps=%b bs=%b pr=%b se=%b data=%h -> pc=%h ir_fields=%h/%h/%h stat=%h halted=%b br=%h",
                     i, vecs[i].il, vecs[i].pw, vecs[i].ps, vecs[i].bs, vecs[i].pr, vecs[i].se,
                     vecs[i].data, bus.imem_addr, bus.opcode, bus.mm, bus.imm, bus.stat,
                     bus.halted, bus.br_addr);
        end

        // Asynchronous reset mid-cycle: state must clear without a clock edge
        @(negedge clk);
        idle();
        @(posedge clk);
        #2;
        rst_f = 1'b0;
        #1;
        chk_state(100, z);
        $display("async reset: pc=%h opcode=%h stat=%h halted=%b", bus.imem_addr, bus.opcode, bus.stat, bus.halted);

        // After release, fetch works again (halt was cleared)
        @(negedge clk);
        rst_f = 1'b1;
        drive(mk(1, 1, 0, 0, 0, 0, 4'h0, 32'h50000007, 16'h0, 32'h0, 4'h0, 0, 16'h0, 16'd0));
        @(posedge clk);
        #1;
        chk_state(101, mk(0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 16'h0001, 32'h50000007, 4'h0, 0, 16'h0008, 16'd1));
        $display("post-reset fetch: pc=%h opcode=%h imm=%h halted=%b", bus.imem_addr, bus.opcode, bus.imm, bus.halted);

        @(negedge clk);
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
